// File: rtl/reorder_buffer_if.sv
// Dispatcher / CDB / commit bundle of the reorder buffer.
// master = surrounding core side, slave = the buffer itself.
interface reorder_buffer_if #(
   parameter int ROBWidth = 4,
   parameter int IDWidth  = 32,
   parameter int RegWidth = 5
) ();
   logic                dispatcher_rob_en_in;
   logic [1:0]          dispatcher_rob_type_in;
   logic [RegWidth-1:0] dispatcher_rob_rd_in;
   logic                rob_dispatcher_full_out;
   logic [ROBWidth-1:0] rob_dispatcher_tag_out;
   logic [ROBWidth-1:0] dispatcher_rob_qs_in;
   logic [ROBWidth-1:0] dispatcher_rob_qt_in;
   logic                rob_dispatcher_qs_ready_out;
   logic                rob_dispatcher_qt_ready_out;
   logic [IDWidth-1:0]  rob_dispatcher_qs_value_out;
   logic [IDWidth-1:0]  rob_dispatcher_qt_value_out;
   logic                cdb_rob_en_in;
   logic [ROBWidth-1:0] cdb_rob_tag_in;
   logic [IDWidth-1:0]  cdb_rob_value_in;
   logic                cdb_rob_mispredict_in;
   logic [IDWidth-1:0]  cdb_rob_target_in;
   logic                rob_regfile_en_out;
   logic [RegWidth-1:0] rob_regfile_d_out;
   logic [IDWidth-1:0]  rob_regfile_value_out;
   logic [ROBWidth-1:0] rob_regfile_h_out;
   logic                rob_regfile_rst_out;
   logic                rob_lsb_store_commit_out;
   logic                rob_flush_out;
   logic [IDWidth-1:0]  rob_fetcher_pc_out;

   modport master (
      output dispatcher_rob_en_in, dispatcher_rob_type_in,
      output dispatcher_rob_rd_in,
      output dispatcher_rob_qs_in, dispatcher_rob_qt_in,
      output cdb_rob_en_in, cdb_rob_tag_in, cdb_rob_value_in,
      output cdb_rob_mispredict_in, cdb_rob_target_in,
      input  rob_dispatcher_full_out, rob_dispatcher_tag_out,
      input  rob_dispatcher_qs_ready_out, rob_dispatcher_qt_ready_out,
      input  rob_dispatcher_qs_value_out, rob_dispatcher_qt_value_out,
      input  rob_regfile_en_out, rob_regfile_d_out,
      input  rob_regfile_value_out, rob_regfile_h_out,
      input  rob_regfile_rst_out, rob_lsb_store_commit_out,
      input  rob_flush_out, rob_fetcher_pc_out
   );

   modport slave (
      input  dispatcher_rob_en_in, dispatcher_rob_type_in,
      input  dispatcher_rob_rd_in,
      input  dispatcher_rob_qs_in, dispatcher_rob_qt_in,
      input  cdb_rob_en_in, cdb_rob_tag_in, cdb_rob_value_in,
      input  cdb_rob_mispredict_in, cdb_rob_target_in,
      output rob_dispatcher_full_out, rob_dispatcher_tag_out,
      output rob_dispatcher_qs_ready_out, rob_dispatcher_qt_ready_out,
      output rob_dispatcher_qs_value_out, rob_dispatcher_qt_value_out,
      output rob_regfile_en_out, rob_regfile_d_out,
      output rob_regfile_value_out, rob_regfile_h_out,
      output rob_regfile_rst_out, rob_lsb_store_commit_out,
      output rob_flush_out, rob_fetcher_pc_out
   );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate, CDB capture,
// operand lookup with bypass, single in-order commit, flush.
module reorder_buffer #(
   parameter int ROBWidth = 4,
   parameter int IDWidth  = 32,
   parameter int RegWidth = 5
) (
   input logic             clk_in,
   input logic             rst_in,
   input logic             rdy_in,
   reorder_buffer_if.slave bus
);
   localparam int Depth = 1 << ROBWidth;
   localparam logic [ROBWidth:0] FullCnt = (ROBWidth+1)'(Depth);
   localparam logic [1:0] TyBr = 2'd1;
   localparam logic [1:0] TySt = 2'd2;

   typedef struct packed {
      logic                busy;
      logic                ready;
      logic [1:0]          kind;
      logic [RegWidth-1:0] rd;
      logic [IDWidth-1:0]  value;
      logic                mispredict;
      logic [IDWidth-1:0]  target;
   } entry_t;

   entry_t ent [Depth];

   logic [ROBWidth-1:0] head, tail;
   logic [ROBWidth:0]   count;

   logic                rf_en_q, st_q, fl_q;
   logic [RegWidth-1:0] rf_d_q;
   logic [IDWidth-1:0]  rf_v_q, pc_q;
   logic [ROBWidth-1:0] rf_h_q;

   entry_t hd_e;
   logic   full, do_commit, do_flush, blocked;
   logic   do_alloc, do_cdb;

   always_comb begin
      hd_e      = ent[head];
      full      = (count == FullCnt);
      do_commit = rdy_in & hd_e.busy & hd_e.ready;
      do_flush  = do_commit & (hd_e.kind == TyBr) & hd_e.mispredict;
      // squash inputs both at the flushing edge and while the pulse is out
      blocked   = do_flush | fl_q;
      do_alloc  = rdy_in & bus.dispatcher_rob_en_in & ~full & ~blocked;
      do_cdb    = rdy_in & bus.cdb_rob_en_in & ~blocked
                & ent[bus.cdb_rob_tag_in].busy;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < Depth; i++) ent[i] <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         rf_en_q <= 1'b0;
         st_q    <= 1'b0;
         fl_q    <= 1'b0;
         rf_d_q  <= '0;
         rf_v_q  <= '0;
         rf_h_q  <= '0;
         pc_q    <= '0;
      end else if (rdy_in) begin
         rf_en_q <= 1'b0;
         st_q    <= 1'b0;
         fl_q    <= do_flush;
         rf_d_q  <= '0;
         rf_v_q  <= '0;
         rf_h_q  <= '0;
         pc_q    <= '0;
         if (do_cdb) begin
            ent[bus.cdb_rob_tag_in].ready      <= 1'b1;
            ent[bus.cdb_rob_tag_in].value      <= bus.cdb_rob_value_in;
            ent[bus.cdb_rob_tag_in].mispredict <= bus.cdb_rob_mispredict_in;
            ent[bus.cdb_rob_tag_in].target     <= bus.cdb_rob_target_in;
         end
         if (do_alloc) begin
            ent[tail].busy       <= 1'b1;
            ent[tail].ready      <= 1'b0;
            ent[tail].kind       <= bus.dispatcher_rob_type_in;
            ent[tail].rd         <= bus.dispatcher_rob_rd_in;
            ent[tail].mispredict <= 1'b0;
         end
         if (do_commit) begin
            ent[head].busy <= 1'b0;
            head           <= head + 1'b1;
            if (hd_e.kind == TySt) begin
               st_q <= 1'b1;
            end else begin
               rf_en_q <= 1'b1;
               rf_d_q  <= hd_e.rd;
               rf_v_q  <= hd_e.value;
               rf_h_q  <= head;
            end
         end
         if (do_flush) begin
            for (int i = 0; i < Depth; i++) ent[i].busy <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pc_q  <= hd_e.target;
         end else begin
            tail  <= tail + ROBWidth'(do_alloc);
            count <= count + (ROBWidth+1)'(do_alloc)
                           - (ROBWidth+1)'(do_commit);
         end
      end else begin
         rf_en_q <= 1'b0;
         st_q    <= 1'b0;
         fl_q    <= 1'b0;
      end
   end

   always_comb begin
      bus.rob_dispatcher_qs_ready_out = ent[bus.dispatcher_rob_qs_in].ready;
      bus.rob_dispatcher_qs_value_out = ent[bus.dispatcher_rob_qs_in].value;
      bus.rob_dispatcher_qt_ready_out = ent[bus.dispatcher_rob_qt_in].ready;
      bus.rob_dispatcher_qt_value_out = ent[bus.dispatcher_rob_qt_in].value;
      if (bus.cdb_rob_en_in
          && bus.cdb_rob_tag_in == bus.dispatcher_rob_qs_in) begin
         bus.rob_dispatcher_qs_ready_out = 1'b1;
         bus.rob_dispatcher_qs_value_out = bus.cdb_rob_value_in;
      end
      if (bus.cdb_rob_en_in
          && bus.cdb_rob_tag_in == bus.dispatcher_rob_qt_in) begin
         bus.rob_dispatcher_qt_ready_out = 1'b1;
         bus.rob_dispatcher_qt_value_out = bus.cdb_rob_value_in;
      end
   end

   assign bus.rob_dispatcher_full_out  = full;
   assign bus.rob_dispatcher_tag_out   = tail;
   assign bus.rob_regfile_en_out       = rf_en_q;
   assign bus.rob_regfile_d_out        = rf_d_q;
   assign bus.rob_regfile_value_out    = rf_v_q;
   assign bus.rob_regfile_h_out        = rf_h_q;
   assign bus.rob_regfile_rst_out      = fl_q;
   assign bus.rob_lsb_store_commit_out = st_q;
   assign bus.rob_flush_out            = fl_q;
   assign bus.rob_fetcher_pc_out       = pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: row table for in-order commit plus
// hand sequences; commit outputs checked against a scoreboard.
module tb_reorder_buffer;
   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   always #5 clk_in = ~clk_in;

   reorder_buffer_if #(.ROBWidth(4), .IDWidth(32), .RegWidth(5)) bus ();

   reorder_buffer #(.ROBWidth(4), .IDWidth(32), .RegWidth(5)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rdy_in(rdy_in),
      .bus   (bus)
   );

   typedef struct {
      logic        rf;
      logic        st;
      logic        fl;
      logic        rr;
      logic [4:0]  d;
      logic [31:0] v;
      logic [3:0]  h;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      logic        a_en;
      logic [1:0]  a_ty;
      logic [4:0]  a_rd;
      logic        c_en;
      logic [3:0]  c_tag;
      logic [31:0] c_val;
      logic [3:0]  q;
      logic [3:0]  e_tag;
      logic        e_full;
      logic        e_rdy;
      logic [31:0] e_val;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];
   int   errors = 0;
   int   checks = 0;
   bit   mon_on = 1'b0;
   logic [4:0] m_rd[16];
   int   nt, hd;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic push_rf(input logic [4:0] d, input logic [31:0] v,
                          input logic [3:0] h);
      exp_t e;
      e = '{rf: 1'b1, st: 1'b0, fl: 1'b0, rr: 1'b0,
            d: d, v: v, h: h, pc: 32'h0};
      sb.push_back(e);
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (mon_on && !rst_in) begin
         if (bus.rob_regfile_en_out || bus.rob_lsb_store_commit_out
             || bus.rob_flush_out || bus.rob_regfile_rst_out) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: got rf=%0b st=%0b fl=%0b h=%0d want none",
                        bus.rob_regfile_en_out, bus.rob_lsb_store_commit_out,
                        bus.rob_flush_out, bus.rob_regfile_h_out);
            end else begin
               e = sb.pop_front();
               chk("commit_rf_en", 32'(bus.rob_regfile_en_out), 32'(e.rf));
               chk("commit_store", 32'(bus.rob_lsb_store_commit_out), 32'(e.st));
               chk("commit_flush", 32'(bus.rob_flush_out), 32'(e.fl));
               chk("commit_rf_rst", 32'(bus.rob_regfile_rst_out), 32'(e.rr));
               if (e.rf) begin
                  chk("commit_d", 32'(bus.rob_regfile_d_out), 32'(e.d));
                  chk("commit_value", bus.rob_regfile_value_out, e.v);
                  chk("commit_h", 32'(bus.rob_regfile_h_out), 32'(e.h));
               end
               if (e.fl) chk("flush_pc", bus.rob_fetcher_pc_out, e.pc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      bus.dispatcher_rob_en_in   = 1'b0;
      bus.dispatcher_rob_type_in = 2'd0;
      bus.dispatcher_rob_rd_in   = 5'd0;
      bus.cdb_rob_en_in          = 1'b0;
      bus.cdb_rob_tag_in         = 4'd0;
      bus.cdb_rob_value_in       = 32'h0;
      bus.cdb_rob_mispredict_in  = 1'b0;
      bus.cdb_rob_target_in      = 32'h0;
   endtask

   task automatic alloc_set(input logic [1:0] ty, input logic [4:0] rd);
      bus.dispatcher_rob_en_in   = 1'b1;
      bus.dispatcher_rob_type_in = ty;
      bus.dispatcher_rob_rd_in   = rd;
   endtask

   task automatic cdb_set(input logic [3:0] tag, input logic [31:0] val,
                          input logic mp, input logic [31:0] tgt);
      bus.cdb_rob_en_in         = 1'b1;
      bus.cdb_rob_tag_in        = tag;
      bus.cdb_rob_value_in      = val;
      bus.cdb_rob_mispredict_in = mp;
      bus.cdb_rob_target_in     = tgt;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d pending commits want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      sb.delete();
      step();
      step();
      rst_in = 1'b0;
      step();
   endtask

   task automatic set_row(input int i, input logic a, input logic [1:0] ty,
                          input logic [4:0] rd, input logic c,
                          input logic [3:0] ct, input logic [31:0] cv,
                          input logic [3:0] q, input logic [3:0] et,
                          input logic er, input logic [31:0] ev);
      tbl[i] = '{a_en: a, a_ty: ty, a_rd: rd, c_en: c, c_tag: ct,
                 c_val: cv, q: q, e_tag: et, e_full: 1'b0,
                 e_rdy: er, e_val: ev};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] t;
      logic [4:0] rd;
      logic [31:0] v;
      exp_t e;

      set_row(0, 1'b1, 2'd0, 5'd1, 1'b0, 4'd0, 32'h0,  4'd0, 4'd0, 1'b0, 32'h0);
      set_row(1, 1'b1, 2'd0, 5'd2, 1'b0, 4'd0, 32'h0,  4'd0, 4'd1, 1'b0, 32'h0);
      set_row(2, 1'b1, 2'd0, 5'd3, 1'b0, 4'd0, 32'h0,  4'd1, 4'd2, 1'b0, 32'h0);
      set_row(3, 1'b0, 2'd0, 5'd0, 1'b1, 4'd2, 32'h33, 4'd2, 4'd3, 1'b1, 32'h33);
      set_row(4, 1'b0, 2'd0, 5'd0, 1'b1, 4'd0, 32'h11, 4'd2, 4'd3, 1'b1, 32'h33);
      set_row(5, 1'b0, 2'd0, 5'd0, 1'b1, 4'd1, 32'h22, 4'd0, 4'd3, 1'b1, 32'h11);
      set_row(6, 1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd1, 4'd3, 1'b1, 32'h22);
      set_row(7, 1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd2, 4'd3, 1'b1, 32'h33);
      set_row(8, 1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd3, 4'd3, 1'b0, 32'h0);
      set_row(9, 1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,  4'd3, 4'd3, 1'b0, 32'h0);

      idle();
      bus.dispatcher_rob_qs_in = 4'd0;
      bus.dispatcher_rob_qt_in = 4'd0;
      rdy_in = 1'b1;
      rst_in = 1'b1;
      #12;
      chk("reset_tag", 32'(bus.rob_dispatcher_tag_out), 32'd0);
      chk("reset_full", 32'(bus.rob_dispatcher_full_out), 32'd0);
      chk("reset_rf_en", 32'(bus.rob_regfile_en_out), 32'd0);
      chk("reset_flush", 32'(bus.rob_flush_out), 32'd0);
      chk("reset_store", 32'(bus.rob_lsb_store_commit_out), 32'd0);
      chk("reset_pc", bus.rob_fetcher_pc_out, 32'h0);
      step();
      rst_in = 1'b0;
      mon_on = 1'b1;

      // in-order commit, table driven
      push_rf(5'd1, 32'h11, 4'd0);
      push_rf(5'd2, 32'h22, 4'd1);
      push_rf(5'd3, 32'h33, 4'd2);
      for (int i = 0; i < 10; i++) begin
         idle();
         if (tbl[i].a_en) alloc_set(tbl[i].a_ty, tbl[i].a_rd);
         if (tbl[i].c_en) cdb_set(tbl[i].c_tag, tbl[i].c_val, 1'b0, 32'h0);
         bus.dispatcher_rob_qs_in = tbl[i].q;
         bus.dispatcher_rob_qt_in = tbl[i].q;
         #1;
         chk($sformatf("row%0d_tag", i), 32'(bus.rob_dispatcher_tag_out), 32'(tbl[i].e_tag));
         chk($sformatf("row%0d_full", i), 32'(bus.rob_dispatcher_full_out), 32'(tbl[i].e_full));
         chk($sformatf("row%0d_qs_rdy", i), 32'(bus.rob_dispatcher_qs_ready_out), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d_qs_val", i), bus.rob_dispatcher_qs_value_out, tbl[i].e_val);
         chk($sformatf("row%0d_qt_rdy", i), 32'(bus.rob_dispatcher_qt_ready_out), 32'(tbl[i].e_rdy));
         step();
      end
      idle();
      wait_drain("inorder_drain", 20);

      // forwarding: tail is at 3, allocate 3,4,5
      for (int i = 3; i < 6; i++) begin
         alloc_set(2'd0, 5'(i + 10));
         #1;
         chk("fwd_alloc_tag", 32'(bus.rob_dispatcher_tag_out), 32'(i));
         step();
      end
      idle();
      bus.dispatcher_rob_qs_in = 4'd5;
      bus.dispatcher_rob_qt_in = 4'd4;
      #1;
      chk("fwd_not_ready", 32'(bus.rob_dispatcher_qs_ready_out), 32'd0);
      cdb_set(4'd5, 32'hABCD, 1'b0, 32'h0);
      #1;
      chk("fwd_bypass_rdy", 32'(bus.rob_dispatcher_qs_ready_out), 32'd1);
      chk("fwd_bypass_val", bus.rob_dispatcher_qs_value_out, 32'hABCD);
      chk("fwd_other_tag", 32'(bus.rob_dispatcher_qt_ready_out), 32'd0);
      step();
      idle();
      #1;
      chk("fwd_stored_rdy", 32'(bus.rob_dispatcher_qs_ready_out), 32'd1);
      chk("fwd_stored_val", bus.rob_dispatcher_qs_value_out, 32'hABCD);

      // asynchronous reset mid-run with rdy low
      rdy_in = 1'b0;
      rst_in = 1'b1;
      #2;
      chk("midrst_tag", 32'(bus.rob_dispatcher_tag_out), 32'd0);
      chk("midrst_full", 32'(bus.rob_dispatcher_full_out), 32'd0);
      chk("midrst_qs_rdy", 32'(bus.rob_dispatcher_qs_ready_out), 32'd0);
      chk("midrst_qs_val", bus.rob_dispatcher_qs_value_out, 32'h0);
      step();
      rst_in = 1'b0;
      rdy_in = 1'b1;
      step();

      // full and wrap
      nt = 0;
      hd = 0;
      for (int i = 0; i < 16; i++) begin
         alloc_set(2'd0, 5'(i + 1));
         m_rd[i] = 5'(i + 1);
         #1;
         chk("fill_tag", 32'(bus.rob_dispatcher_tag_out), 32'(nt % 16));
         step();
         nt++;
      end
      idle();
      #1;
      chk("full_set", 32'(bus.rob_dispatcher_full_out), 32'd1);
      alloc_set(2'd0, 5'd31);
      step();
      idle();
      #1;
      chk("full_ignored_full", 32'(bus.rob_dispatcher_full_out), 32'd1);
      chk("full_ignored_tag", 32'(bus.rob_dispatcher_tag_out), 32'd0);
      cdb_set(4'd0, 32'hA0, 1'b0, 32'h0);
      push_rf(m_rd[0], 32'hA0, 4'd0);
      step();
      idle();
      wait_drain("full_commit1", 20);
      hd = 1;
      chk("after_commit_full", 32'(bus.rob_dispatcher_full_out), 32'd0);
      chk("after_commit_tag", 32'(bus.rob_dispatcher_tag_out), 32'(nt % 16));
      alloc_set(2'd0, 5'd20);
      m_rd[nt % 16] = 5'd20;
      step();
      nt++;
      idle();
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 16; j++) begin
            t = 4'((hd + j) % 16);
            v = 32'h1000 * (r + 1) + 32'(j);
            cdb_set(t, v, 1'b0, 32'h0);
            push_rf(m_rd[t], v, t);
            step();
         end
         idle();
         wait_drain("wrap_drain", 40);
         #1;
         chk("wrap_empty_full", 32'(bus.rob_dispatcher_full_out), 32'd0);
         for (int j = 0; j < 16; j++) begin
            rd = 5'((j * 5 + r) % 32);
            alloc_set(2'd0, rd);
            m_rd[nt % 16] = rd;
            #1;
            chk("wrap_tag", 32'(bus.rob_dispatcher_tag_out), 32'(nt % 16));
            step();
            nt++;
         end
         idle();
         #1;
         chk("wrap_refull", 32'(bus.rob_dispatcher_full_out), 32'd1);
      end

      // mispredicted branch at head
      do_reset();
      alloc_set(2'd1, 5'd7);
      step();
      alloc_set(2'd0, 5'd8);
      step();
      alloc_set(2'd0, 5'd9);
      step();
      idle();
      cdb_set(4'd1, 32'h1, 1'b0, 32'h0);
      step();
      cdb_set(4'd2, 32'h2, 1'b0, 32'h0);
      step();
      e = '{rf: 1'b1, st: 1'b0, fl: 1'b1, rr: 1'b1,
            d: 5'd7, v: 32'h44, h: 4'd0, pc: 32'h1000};
      sb.push_back(e);
      cdb_set(4'd0, 32'h44, 1'b1, 32'h1000);
      step();
      idle();
      step();
      alloc_set(2'd0, 5'd12);
      cdb_set(4'd1, 32'h55, 1'b0, 32'h0);
      step();
      idle();
      #1;
      chk("flush_tag", 32'(bus.rob_dispatcher_tag_out), 32'd0);
      chk("flush_full", 32'(bus.rob_dispatcher_full_out), 32'd0);
      wait_drain("flush_drain", 10);
      repeat (4) step();

      // store commit held off by rdy
      do_reset();
      alloc_set(2'd2, 5'd0);
      step();
      idle();
      cdb_set(4'd0, 32'h99, 1'b0, 32'h0);
      step();
      idle();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rdy_low_store", 32'(bus.rob_lsb_store_commit_out), 32'd0);
      end
      e = '{rf: 1'b0, st: 1'b1, fl: 1'b0, rr: 1'b0,
            d: 5'd0, v: 32'h0, h: 4'd0, pc: 32'h0};
      sb.push_back(e);
      rdy_in = 1'b1;
      wait_drain("store_drain", 10);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
